lfsr_seq_checker: RTL and testbench

Receive-side checker for the 8-bit LFSR pattern that the test-chip counter block drives onto the bidirectional pins, one new value per display-digit strobe. It samples the incoming byte on each strobe and synchronises a local copy of the same LFSR to it. Once synchronised it counts mismatching bytes and reports lock status. It sits on the receiving board or tile, fed from `uio_in` plus a strobe.

---
 rtl/lfsr_seq_checker.sv | 184 ++++++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: receive-side checker for the 8-bit LFSR test pattern.
// Syncs a local LFSR to strobed bytes, then flywheels, counts errors, flags loss.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   strb       in   sample enable for data_in
//   data_in    in   [7:0] received LFSR byte
//   clr_err    in   synchronous clear of err_count (wins over an increment)
//   locked     out  checker is in LOCKED
//   err_pulse  out  one-cycle pulse per mismatching byte while locked
//   err_count  out  [15:0] saturating mismatch count
//   lost       out  sticky loss-of-lock flag
//
// Build option: define LFSR_CHK_RESYNC_EN to drop back to SEARCH on loss of
// lock. Without it, the checker stays in LOCKED until reset.

module lfsr_seq_checker #(
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned LOSS_COUNT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        strb,
   input  logic [7:0]  data_in,
   input  logic        clr_err,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic        lost
);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   // Thresholds widened by one bit so run+1 never wraps.
   localparam logic [4:0] LP_LOCK = 5'(LOCK_COUNT);
   localparam logic [4:0] LP_LOSS = 5'(LOSS_COUNT);
   localparam logic [3:0] LP_LOSS_SAT = 4'(LOSS_COUNT);

   // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
   function automatic logic [7:0] f_step(input logic [7:0] d);
      return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
   endfunction

   state_t      r_state;
   logic [7:0]  r_pred;
   logic [3:0]  r_run;
   logic        r_locked;
   logic        r_err_pulse;
   logic [15:0] r_err_count;
   logic        r_lost;

   state_t      w_state_nxt;
   logic [7:0]  w_pred_nxt;
   logic [3:0]  w_run_nxt;
   logic        w_locked_nxt;
   logic        w_err_pulse_nxt;
   logic [15:0] w_err_count_nxt;
   logic        w_lost_nxt;

   logic        w_match;
   logic        w_data_zero;
   logic [4:0]  w_run_inc;
   logic [7:0]  w_step_data;
   logic [7:0]  w_step_pred;
   logic        w_cnt_sat;

   assign w_match     = (data_in == r_pred);
   assign w_data_zero = (data_in == 8'h00);
   assign w_run_inc   = {1'b0, r_run} + 5'd1;
   assign w_step_data = f_step(data_in);
   assign w_step_pred = f_step(r_pred);
   assign w_cnt_sat   = &r_err_count;

   always_comb begin
      w_state_nxt     = r_state;
      w_pred_nxt      = r_pred;
      w_run_nxt       = r_run;
      w_err_pulse_nxt = 1'b0;
      w_err_count_nxt = r_err_count;
      w_lost_nxt      = r_lost;

      case (r_state)
         S_SEARCH: begin
            // Zero is the lock-up state and never a usable seed.
            if (strb && !w_data_zero) begin
               w_pred_nxt  = w_step_data;
               w_run_nxt   = 4'd0;
               w_state_nxt = S_VERIFY;
            end
         end

         S_VERIFY: begin
            if (strb) begin
               if (w_match) begin
                  w_pred_nxt = w_step_data;
                  if (w_run_inc == LP_LOCK) begin
                     w_run_nxt   = 4'd0;
                     w_state_nxt = S_LOCKED;
                  end else begin
                     w_run_nxt = w_run_inc[3:0];
                  end
               end else if (!w_data_zero) begin
                  // Reseed from the byte just seen.
                  w_pred_nxt = w_step_data;
                  w_run_nxt  = 4'd0;
               end else begin
                  w_state_nxt = S_SEARCH;
               end
            end
         end

         S_LOCKED: begin
            if (strb) begin
               // Flywheel: prediction advances on its own, ignoring data.
               w_pred_nxt = w_step_pred;
               if (w_match) begin
                  w_run_nxt = 4'd0;
               end else begin
                  w_err_pulse_nxt = 1'b1;
                  if (!w_cnt_sat) begin
                     w_err_count_nxt = r_err_count + 16'd1;
                  end
                  if (w_run_inc >= LP_LOSS) begin
                     w_lost_nxt = 1'b1;
`ifdef LFSR_CHK_RESYNC_EN
                     w_run_nxt   = 4'd0;
                     w_state_nxt = S_SEARCH;
`else
                     // Hold at threshold; stay locked and keep counting.
                     w_run_nxt = LP_LOSS_SAT;
`endif
                  end else begin
                     w_run_nxt = w_run_inc[3:0];
                  end
               end
            end
         end

         default: begin
            w_state_nxt = S_SEARCH;
            w_pred_nxt  = 8'h00;
            w_run_nxt   = 4'd0;
         end
      endcase

      // Clear beats a same-cycle increment; the pulse is unaffected.
      if (clr_err) begin
         w_err_count_nxt = 16'd0;
      end
   end

   assign w_locked_nxt = (w_state_nxt == S_LOCKED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_SEARCH;
         r_pred      <= 8'h00;
         r_run       <= 4'd0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_count <= 16'd0;
         r_lost      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pred      <= w_pred_nxt;
         r_run       <= w_run_nxt;
         r_locked    <= w_locked_nxt;
         r_err_pulse <= w_err_pulse_nxt;
         r_err_count <= w_err_count_nxt;
         r_lost      <= w_lost_nxt;
      end
   end

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;
   assign lost      = r_lost;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: directed and random stimulus for lfsr_seq_checker,
// compared against a behavioural model of the sync/flywheel rules.

module tb_lfsr_seq_checker;

   localparam int LOCK_N = 4;
   localparam int LOSS_N = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        strb;
   logic [7:0]  data_in;
   logic        clr_err;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic        lost;

   int n_checks = 0;
   int n_errors = 0;

   // Model: phase 0 = hunting, 1 = confirming, 2 = locked.
   int         m_phase;
   logic [7:0] m_pred;
   int         m_run;
   int         m_cnt;
   bit         m_pulse;
   bit         m_lost;

   always #5 clk = ~clk;

   lfsr_seq_checker #(
      .LOCK_COUNT(LOCK_N),
      .LOSS_COUNT(LOSS_N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .strb      (strb),
      .data_in   (data_in),
      .clr_err   (clr_err),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .lost      (lost)
   );

   function automatic logic [7:0] lfsr_next(input logic [7:0] d);
      logic [7:0] sh;
      sh = (d << 1) & 8'hFE;
      return sh | {7'd0, ^(d & 8'hB8)};
   endfunction

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_pred  = 8'h00;
      m_run   = 0;
      m_cnt   = 0;
      m_pulse = 1'b0;
      m_lost  = 1'b0;
   endtask

   task automatic model_step(input bit s, input logic [7:0] d, input bit c);
      bit hit;
      m_pulse = 1'b0;
      if (s) begin
         if (m_phase == 0) begin
            if (d != 8'h00) begin
               m_pred  = lfsr_next(d);
               m_run   = 0;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (d == m_pred) begin
               m_pred = lfsr_next(d);
               m_run  = m_run + 1;
               if (m_run == LOCK_N) begin
                  m_phase = 2;
                  m_run   = 0;
               end
            end else if (d != 8'h00) begin
               m_pred = lfsr_next(d);
               m_run  = 0;
            end else begin
               m_phase = 0;
            end
         end else begin
            hit    = (d == m_pred);
            m_pred = lfsr_next(m_pred);
            if (hit) begin
               m_run = 0;
            end else begin
               m_pulse = 1'b1;
               if (m_cnt < 65535) m_cnt = m_cnt + 1;
               m_run = m_run + 1;
               if (m_run >= LOSS_N) begin
                  m_lost = 1'b1;
`ifdef LFSR_CHK_RESYNC_EN
                  m_phase = 0;
                  m_run   = 0;
`else
                  m_run = LOSS_N;
`endif
               end
            end
         end
      end
      if (c) m_cnt = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".locked"}, {31'd0, locked}, {31'd0, m_phase == 2});
      check({tag, ".pulse"}, {31'd0, err_pulse}, {31'd0, m_pulse});
      check({tag, ".count"}, {16'd0, err_count}, m_cnt);
      check({tag, ".lost"}, {31'd0, lost}, {31'd0, m_lost});
   endtask

   // Called just after a rising edge; applies one cycle of inputs.
   task automatic cycle(input bit s, input logic [7:0] d, input bit c);
      strb    = s;
      data_in = d;
      clr_err = c;
      @(posedge clk);
      model_step(s, d, c);
      #1;
      strb    = 1'b0;
      clr_err = 1'b0;
      check_all("cyc");
   endtask

   // Asynchronous reset pulse asserted between clock edges.
   task automatic do_reset();
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all("rst");
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic lock_seq();
      cycle(1'b1, 8'h01, 1'b0);
      cycle(1'b1, 8'h02, 1'b0);
      cycle(1'b1, 8'h04, 1'b0);
      cycle(1'b1, 8'h08, 1'b0);
      cycle(1'b1, 8'h11, 1'b0);
   endtask

   task automatic bad(input bit c);
      cycle(1'b1, m_pred ^ 8'h5A, c);
   endtask

   initial begin
      bit         s;
      bit         c;
      logic [7:0] d;
      int         r;
      int         k;

      reset   = 1'b1;
      strb    = 1'b0;
      clr_err = 1'b0;
      data_in = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("por");
      check("por_cnt", {16'd0, err_count}, 32'd0);
      reset = 1'b0;

      // Lock acquisition
      cycle(1'b1, 8'h01, 1'b0);
      check("acq1", {31'd0, locked}, 32'd0);
      cycle(1'b1, 8'h02, 1'b0);
      cycle(1'b1, 8'h04, 1'b0);
      cycle(1'b1, 8'h08, 1'b0);
      check("acq4", {31'd0, locked}, 32'd0);
      cycle(1'b1, 8'h11, 1'b0);
      check("acq5", {31'd0, locked}, 32'd1);
      check("acq_cnt", {16'd0, err_count}, 32'd0);

      // Single error while locked, then flywheel match
      cycle(1'b1, 8'h23, 1'b0);
      cycle(1'b1, 8'hFF, 1'b0);
      check("se_pls", {31'd0, err_pulse}, 32'd1);
      check("se_cnt", {16'd0, err_count}, 32'd1);
      check("se_lk", {31'd0, locked}, 32'd1);
      cycle(1'b1, 8'h8E, 1'b0);
      check("fly_pls", {31'd0, err_pulse}, 32'd0);
      check("fly_cnt", {16'd0, err_count}, 32'd1);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h55, 1'b0);

      // Zero seeds rejected
      do_reset();
      repeat (3) begin
         cycle(1'b1, 8'h00, 1'b0);
         check("zs_lk", {31'd0, locked}, 32'd0);
      end
      cycle(1'b1, 8'h01, 1'b0);
      cycle(1'b1, 8'h02, 1'b0);
      cycle(1'b1, 8'h04, 1'b0);
      cycle(1'b1, 8'h08, 1'b0);
      check("zs_unlk", {31'd0, locked}, 32'd0);
      cycle(1'b1, 8'h11, 1'b0);
      check("zs_lk5", {31'd0, locked}, 32'd1);

      // Loss of lock
      do_reset();
      lock_seq();
      repeat (7) bad(1'b0);
      check("loss7", {31'd0, lost}, 32'd0);
      bad(1'b0);
      check("loss_cnt", {16'd0, err_count}, 32'd8);
      check("loss_lost", {31'd0, lost}, 32'd1);
`ifdef LFSR_CHK_RESYNC_EN
      check("loss_lk", {31'd0, locked}, 32'd0);
`else
      check("loss_lk", {31'd0, locked}, 32'd1);
      bad(1'b0);
      check("loss_cnt9", {16'd0, err_count}, 32'd9);
`endif

      // Clear vs. error collision
      do_reset();
      lock_seq();
      repeat (5) bad(1'b0);
      check("col_cnt5", {16'd0, err_count}, 32'd5);
      bad(1'b1);
      check("col_cnt0", {16'd0, err_count}, 32'd0);
      check("col_pls", {31'd0, err_pulse}, 32'd1);
      bad(1'b0);
      check("col_cnt1", {16'd0, err_count}, 32'd1);

      // Reset mid-lock
      do_reset();
      lock_seq();
      repeat (3) bad(1'b0);
      check("rml_cnt3", {16'd0, err_count}, 32'd3);
      do_reset();
      check("rml_cnt0", {16'd0, err_count}, 32'd0);
      cycle(1'b1, 8'h01, 1'b0);
      cycle(1'b1, 8'h02, 1'b0);
      cycle(1'b1, 8'h04, 1'b0);
      cycle(1'b1, 8'h08, 1'b0);
      check("rml_unlk", {31'd0, locked}, 32'd0);
      cycle(1'b1, 8'h11, 1'b0);
      check("rml_lk", {31'd0, locked}, 32'd1);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 999));
         if (r < 2) begin
            do_reset();
         end else if (r < 10) begin
            repeat (10) bad(1'b0);
         end else begin
            s = ($urandom_range(0, 3) != 0);
            k = int'($urandom_range(0, 9));
            if (k < 7 && m_pred != 8'h00) d = m_pred;
            else if (k == 7) d = 8'h00;
            else d = 8'($urandom);
            c = ($urandom_range(0, 49) == 0);
            cycle(s, d, c);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
